// File: rtl/float_pkg.sv
// Shared constants and encodings for the float-to-integer converter pipeline.
package float_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_INT_W = 32;

  // CLS_SAT covers infinities and finite values too large for any INT_W result.
  typedef enum logic [1:0] {
    CLS_NUM = 2'd0,
    CLS_NAN = 2'd1,
    CLS_SAT = 2'd2
  } fp_class_t;

  typedef struct packed {
    logic is_signed;
    logic rnd;
  } mode_t;

endpackage

// File: rtl/float_align_round.sv
// Aligns the significand to integer position and applies truncation or
// round-to-nearest-even, producing an unsigned magnitude one bit wider than INT_W.
module float_align_round
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int INT_W = DEF_INT_W
) (
  input  logic [EXP_W-1:0] exp_f,
  input  logic [MAN_W:0]   mant,
  input  logic             rnd,
  output logic [INT_W:0]   mag
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int SH_W = $clog2(INT_W + 1);
  localparam int X_W  = MAN_W + 1 + INT_W + 1;

  int              exp_unb;
  logic            in_range;
  logic [SH_W-1:0] sh;
  logic [X_W-1:0]  x;
  logic [INT_W:0]  int_part;
  logic            rnd_bit;
  logic            sticky;
  logic            round_up;

  // Binary point sits just above bit MAN_W of x; only exponents -1..INT_W-1
  // can produce a nonzero in-range result, others are clamped to avoid wrap.
  always_comb begin
    exp_unb  = int'(exp_f) - BIAS;
    in_range = (exp_unb >= -1) && (exp_unb <= INT_W - 1);
    sh       = in_range ? SH_W'(exp_unb + 1) : '0;
    x        = {{(INT_W + 1){1'b0}}, mant} << sh;
    if (!in_range) x = '0;
    int_part = x[X_W-1 -: INT_W+1];
    rnd_bit  = x[MAN_W];
    sticky   = |x[MAN_W-1:0];
    round_up = rnd && rnd_bit && (sticky || int_part[0]);
    mag      = int_part + (INT_W + 1)'(round_up);
  end

endmodule

// File: rtl/float_to_int.sv
// Three-stage float-to-integer converter: S1 unpack/classify, S2 align/round,
// S3 sign-apply/saturate/flags, with a single global stall from the output side.
module float_to_int
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int INT_W = DEF_INT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic                   in_signed,
  input  logic                   in_round,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INT_W-1:0]       out_z,
  output logic                   out_invalid,
  output logic                   out_overflow,
  output logic                   out_valid,
  input  logic                   out_ready
);

  // valid/ready: a transfer happens on any rising edge where both are 1;
  // every stage advances together whenever the output is empty or being taken.

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [INT_W-1:0] S_MAX     = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] S_MIN     = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   S_MAX_MAG = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   S_MIN_MAG = {2'b01, {(INT_W-1){1'b0}}};

  logic advance;
  logic s3_valid;

  assign in_ready  = !s3_valid || out_ready;
  assign advance   = in_ready;
  assign out_valid = s3_valid;

  // S1: unpack and classify
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_frac;
  int               a_unb;
  fp_class_t        cls_d;

  always_comb begin
    a_exp  = in_a[EXP_W+MAN_W-1 -: EXP_W];
    a_frac = in_a[MAN_W-1:0];
    a_unb  = int'(a_exp) - BIAS;
    cls_d  = CLS_NUM;
    if (a_exp == '1) cls_d = (a_frac != '0) ? CLS_NAN : CLS_SAT;
    else if (a_unb >= INT_W) cls_d = CLS_SAT;
  end

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0]   s1_mant;
  fp_class_t        s1_cls;
  mode_t            s1_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid          <= in_valid;
      s1_sign           <= in_a[EXP_W+MAN_W];
      s1_exp            <= a_exp;
      s1_mant           <= {(a_exp != '0), a_frac};
      s1_cls            <= cls_d;
      s1_mode.is_signed <= in_signed;
      s1_mode.rnd       <= in_round;
    end
  end

  // S2: alignment and rounding
  logic [INT_W:0] mag_d;

  float_align_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .INT_W(INT_W)
  ) u_align_round (
    .exp_f(s1_exp),
    .mant (s1_mant),
    .rnd  (s1_mode.rnd),
    .mag  (mag_d)
  );

  logic           s2_valid;
  logic           s2_sign;
  fp_class_t      s2_cls;
  logic           s2_is_signed;
  logic [INT_W:0] s2_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid     <= s1_valid;
      s2_sign      <= s1_sign;
      s2_cls       <= s1_cls;
      s2_is_signed <= s1_mode.is_signed;
      s2_mag       <= mag_d;
    end
  end

  // S3: sign application, saturation and flags
  logic [INT_W-1:0] z_d;
  logic [INT_W-1:0] sat_z;
  logic [INT_W-1:0] mag_lo;
  logic             inv_d;
  logic             ovf_d;

  always_comb begin
    z_d    = '0;
    inv_d  = 1'b0;
    ovf_d  = 1'b0;
    mag_lo = s2_mag[INT_W-1:0];
    sat_z  = s2_is_signed ? (s2_sign ? S_MIN : S_MAX) : (s2_sign ? '0 : '1);
    unique case (s2_cls)
      CLS_NAN: inv_d = 1'b1;
      CLS_SAT: ovf_d = 1'b1;
      default: begin
        if (s2_is_signed) begin
          if (s2_sign) ovf_d = (s2_mag > S_MIN_MAG);
          else         ovf_d = (s2_mag > S_MAX_MAG);
          z_d = s2_sign ? -mag_lo : mag_lo;
        end else begin
          // negative values that collapse to 0 are not an overflow
          if (s2_sign) ovf_d = (s2_mag != '0);
          else         ovf_d = s2_mag[INT_W];
          z_d = s2_sign ? '0 : mag_lo;
        end
      end
    endcase
    if (ovf_d) z_d = sat_z;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid     <= 1'b0;
      out_z        <= '0;
      out_invalid  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (advance) begin
      s3_valid     <= s2_valid;
      out_z        <= z_d;
      out_invalid  <= inv_d;
      out_overflow <= ovf_d;
    end
  end

endmodule
